des_key_search_ctrl: RTL

//   Multi-lane brute-force key search controller for the DES cracking top level. Partitions the 56-bit key space

---
 rtl/des_key_search_ctrl_if.sv | 22 ++
 rtl/des_key_search_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/des_key_search_ctrl_if.sv
// Lane-side bus of the DES key search controller: candidate keys out to the
// encrypt cores, ciphertext results and key tags back from them.
interface des_key_search_ctrl_if #(
   parameter int NUM_LANES = 4
);
   logic [NUM_LANES-1:0]    lane_valid;
   logic [NUM_LANES*64-1:0] lane_key;
   logic [NUM_LANES-1:0]    lane_ready;
   logic [NUM_LANES-1:0]    res_valid;
   logic [NUM_LANES*64-1:0] res_ct;
   logic [NUM_LANES*64-1:0] res_key;

   modport master (
      output lane_valid, lane_key,
      input  lane_ready, res_valid, res_ct, res_key
   );

   modport slave (
      input  lane_valid, lane_key,
      output lane_ready, res_valid, res_ct, res_key
   );
endinterface

// File: rtl/des_key_search_ctrl.sv
// Multi-lane brute-force DES key search controller: deals candidate keys to
// NUM_LANES encrypt cores and reports the first key whose ciphertext matches.
module des_key_search_ctrl #(
   parameter int          NUM_LANES = 4,
   parameter logic [56:0] MAX_KEYS  = 57'h80_0000,
   parameter int          COUNT_W   = 56
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic [63:0]           ciphertext,
   input  logic [55:0]           start_key,
   des_key_search_ctrl_if.master lanes,
   output logic [COUNT_W-1:0]    count,
   output logic [63:0]           Key,
   output logic                  Found,
   output logic                  Exhausted,
   output logic                  Busy
);

   localparam int PC_W = $clog2(NUM_LANES + 1);
   localparam int CW1  = COUNT_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      SEARCH,
      DRAIN,
      FOUND,
      EXHAUSTED
   } state_t;

   state_t      state;
   logic [55:0] next_key [NUM_LANES];
   logic [56:0] issued;
   logic [56:0] outstanding;
   logic        armed;

   logic [NUM_LANES-1:0] fire;
   logic [NUM_LANES-1:0] hold;
   logic [NUM_LANES-1:0] valid_nxt;
   logic [55:0]          key_upd [NUM_LANES];
   logic [PC_W-1:0]      fire_cnt;
   logic [PC_W-1:0]      res_cnt;
   logic [56:0]          issued_nxt;
   logic [56:0]          outstanding_nxt;
   logic [56:0]          offered;
   logic [CW1-1:0]       count_sum;
   logic [COUNT_W-1:0]   count_nxt;
   logic                 match_any;
   logic [63:0]          match_key;

   // Each byte is seven raw key bits followed by an odd-parity bit.
   function automatic logic [63:0] expand_key(input logic [55:0] k);
      logic [63:0] r;
      logic [6:0]  g;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         g = k[55-7*j -: 7];
         r[63-8*j -: 8] = {g, ~^g};
      end
      return r;
   endfunction

   always_comb begin
      fire     = lanes.lane_valid & lanes.lane_ready;
      hold     = lanes.lane_valid & ~lanes.lane_ready;
      fire_cnt = '0;
      res_cnt  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         fire_cnt   = fire_cnt + PC_W'(fire[i]);
         res_cnt    = res_cnt + PC_W'(lanes.res_valid[i]);
         key_upd[i] = fire[i] ? next_key[i] + 56'(NUM_LANES) : next_key[i];
      end
      issued_nxt      = issued + 57'(fire_cnt);
      outstanding_nxt = outstanding + 57'(fire_cnt) - 57'(res_cnt);

      // Stalled lanes keep their slot; free budget goes to idle lanes lowest index first.
      offered = issued_nxt;
      for (int i = 0; i < NUM_LANES; i++) begin
         offered = offered + 57'(hold[i]);
      end
      valid_nxt = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (hold[i]) begin
            valid_nxt[i] = 1'b1;
         end else if (offered < MAX_KEYS) begin
            valid_nxt[i] = 1'b1;
            offered      = offered + 57'd1;
         end
      end

      count_sum = {1'b0, count} + CW1'(res_cnt);
      count_nxt = count_sum[COUNT_W] ? '1 : count_sum[COUNT_W-1:0];

      // Scanned downwards so the lowest matching lane wins.
      match_any = 1'b0;
      match_key = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (lanes.res_valid[i] && (lanes.res_ct[64*i +: 64] == ciphertext)) begin
            match_any = 1'b1;
            match_key = lanes.res_key[64*i +: 64];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         lanes.lane_valid <= '0;
         lanes.lane_key   <= '0;
         count            <= '0;
         Key              <= '0;
         Found            <= 1'b0;
         Exhausted        <= 1'b0;
         Busy             <= 1'b0;
         issued           <= '0;
         outstanding      <= '0;
         armed            <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            next_key[i] <= '0;
         end
      end else begin
         // A new search needs Start to have been seen low since the last launch or reset.
         if (!Start) begin
            armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (Start && armed) begin
                  armed       <= 1'b0;
                  count       <= '0;
                  Found       <= 1'b0;
                  Exhausted   <= 1'b0;
                  issued      <= '0;
                  outstanding <= '0;
                  Busy        <= 1'b1;
                  state       <= SEARCH;
                  for (int i = 0; i < NUM_LANES; i++) begin
                     next_key[i] <= start_key + 56'(i);
                  end
               end
            end

            SEARCH: begin
               issued      <= issued_nxt;
               outstanding <= outstanding_nxt;
               count       <= count_nxt;
               for (int i = 0; i < NUM_LANES; i++) begin
                  next_key[i] <= key_upd[i];
                  if (valid_nxt[i]) begin
                     lanes.lane_key[64*i +: 64] <= expand_key(key_upd[i]);
                  end
               end
               if (match_any) begin
                  Key              <= match_key;
                  Found            <= 1'b1;
                  Busy             <= 1'b0;
                  lanes.lane_valid <= '0;
                  state            <= FOUND;
               end else begin
                  lanes.lane_valid <= valid_nxt;
                  if (issued_nxt >= MAX_KEYS) begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               outstanding <= outstanding_nxt;
               count       <= count_nxt;
               if (match_any) begin
                  Key   <= match_key;
                  Found <= 1'b1;
                  Busy  <= 1'b0;
                  state <= FOUND;
               end else if (outstanding_nxt == '0) begin
                  Exhausted <= 1'b1;
                  Busy      <= 1'b0;
                  state     <= EXHAUSTED;
               end
            end

            FOUND, EXHAUSTED: begin
               if (!Start) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
